// File: rtl/reset_seq_pkg.sv
// Shared types, default parameters and parameter legality check for the reset sequencer.
package reset_seq_pkg;

    typedef enum logic [2:0] {
        ASSERT  = 3'd0,
        CHECK   = 3'd1,
        RELEASE = 3'd2,
        GAP     = 3'd3,
        IDLE    = 3'd4
    } state_e;

    localparam int DEF_NUM_STAGES  = 4;
    localparam int DEF_HOLD_CYCLES = 8;
    localparam int DEF_GAP_CYCLES  = 2;
    localparam int DEF_WIDTH       = 16;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic bit params_ok(input int n, input int h, input int g, input int w);
        return (n >= 1) && (n <= 16) && (h >= 1) && (g >= 0) && (w >= 1);
    endfunction

endpackage

// File: rtl/seq_timer.sv
// Saturating up-counter shared by the hold and gap phases; expire_o is high once
// the count has reached limit_i.
module seq_timer #(
    parameter int TW = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clr_i,
    input  logic          en_i,
    input  logic [TW-1:0] limit_i,
    output logic          expire_o
);

    logic [TW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q < limit_i)) begin
            cnt_d = cnt_q + TW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q >= limit_i);

endmodule

// File: rtl/reset_sequencer.sv
// Holds all downstream stages in reset, checks that stage 0's counter cleared,
// then releases the stages one at a time in index order.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_STAGES  = DEF_NUM_STAGES,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
    parameter int WIDTH       = DEF_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  sw_req,
    input  logic [WIDTH-1:0]      count_in,
    output logic [NUM_STAGES-1:0] resetN_out,
    output logic                  busy,
    output logic                  done,
    output logic                  clear_err,
    output logic [2:0]            dbg_state_o
);

    localparam int TW = $clog2(max2(HOLD_CYCLES, GAP_CYCLES) + 1);
    localparam int IW = $clog2(NUM_STAGES + 1);
    localparam logic [TW-1:0] HOLD_LIM = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LIM  = TW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_STAGES - 1);

    if (!params_ok(NUM_STAGES, HOLD_CYCLES, GAP_CYCLES, WIDTH)) begin : g_bad_params
        $error("reset_sequencer: illegal parameter combination");
    end

    state_e                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [NUM_STAGES-1:0] resetN_q, resetN_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  tmr_en, tmr_clr, tmr_expire;
    logic [TW-1:0]         tmr_limit;

    // The timer restarts on every state change and on every software request,
    // so a held sw_req keeps the hold phase pinned at its first cycle.
    assign tmr_clr = sw_req || (state_d != state_q);

    seq_timer #(.TW(TW)) u_timer (
        .clock    (clock),
        .reset    (reset),
        .clr_i    (tmr_clr),
        .en_i     (tmr_en),
        .limit_i  (tmr_limit),
        .expire_o (tmr_expire)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        resetN_d  = resetN_q;
        done_d    = 1'b0;
        err_d     = err_q;
        tmr_en    = 1'b0;
        tmr_limit = HOLD_LIM;

        case (state_q)
            ASSERT: begin
                tmr_en = 1'b1;
                if (tmr_expire) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (count_in != '0) begin
                    err_d = 1'b1;
                end
                resetN_d[0] = 1'b1;
                idx_d       = IW'(1);
                if (NUM_STAGES == 1) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (GAP_CYCLES == 0) begin
                    state_d = RELEASE;
                end else begin
                    state_d = GAP;
                end
            end
            GAP: begin
                tmr_en    = 1'b1;
                tmr_limit = GAP_LIM;
                if (tmr_expire) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                for (int k = 0; k < NUM_STAGES; k++) begin
                    if (idx_q == IW'(k)) begin
                        resetN_d[k] = 1'b1;
                    end
                end
                idx_d = idx_q + IW'(1);
                if (idx_q == LAST_IDX) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (GAP_CYCLES == 0) begin
                    state_d = RELEASE;
                end else begin
                    state_d = GAP;
                end
            end
            IDLE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = ASSERT;
            end
        endcase

        // A software request overrides everything, including the final release.
        if (sw_req) begin
            state_d  = ASSERT;
            idx_d    = '0;
            resetN_d = '0;
            done_d   = 1'b0;
            err_d    = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ASSERT;
            idx_q    <= '0;
            resetN_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            resetN_q <= resetN_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign resetN_out  = resetN_q;
    assign busy        = ~&resetN_q;
    assign done        = done_q;
    assign clear_err   = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: a default instance and a 1-stage/no-gap/1-hold instance
// share stimulus and are checked against a time-since-start reference model.
module tb_reset_sequencer;
    import reset_seq_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        sw_req;
    logic [15:0] count_in;

    logic [3:0]  rn0;
    logic        busy0, done0, err0;
    logic [2:0]  st0;
    logic [0:0]  rn1;
    logic        busy1, done1, err1;
    logic [2:0]  st1;

    always #5 clock = ~clock;

    reset_sequencer dut0 (
        .clock       (clock),
        .reset       (reset),
        .sw_req      (sw_req),
        .count_in    (count_in),
        .resetN_out  (rn0),
        .busy        (busy0),
        .done        (done0),
        .clear_err   (err0),
        .dbg_state_o (st0)
    );

    reset_sequencer #(.NUM_STAGES(1), .HOLD_CYCLES(1), .GAP_CYCLES(0), .WIDTH(16)) dut1 (
        .clock       (clock),
        .reset       (reset),
        .sw_req      (sw_req),
        .count_in    (count_in),
        .resetN_out  (rn1),
        .busy        (busy1),
        .done        (done1),
        .clear_err   (err1),
        .dbg_state_o (st1)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: edges elapsed since the sequence (re)started, per instance.
    int P_N[2] = '{4, 1};
    int P_H[2] = '{8, 1};
    int P_G[2] = '{2, 0};
    int t_m[2];
    bit err_m[2];
    bit done_m[2];

    typedef struct {
        logic        rst;
        logic        sw;
        logic [15:0] cnt;
        logic [3:0]  rn;
        logic        busy;
        logic        done;
        logic        err;
    } vec_t;
    vec_t tbl[24];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int rel_cnt(input int t, input int n, input int h, input int g);
        int r;
        if (t < h + 1) return 0;
        r = (t - h - 1) / (g + 1) + 1;
        return (r > n) ? n : r;
    endfunction

    task automatic model_update(input logic r, input logic s, input logic [15:0] c);
        for (int i = 0; i < 2; i++) begin
            if (r || s) begin
                t_m[i]    = 0;
                err_m[i]  = 1'b0;
                done_m[i] = 1'b0;
            end else begin
                if (t_m[i] < 100000) t_m[i] = t_m[i] + 1;
                if (t_m[i] == P_H[i] + 1 && c != 16'h0) err_m[i] = 1'b1;
                done_m[i] = (t_m[i] == P_H[i] + 1 + (P_N[i] - 1) * (P_G[i] + 1));
            end
        end
    endtask

    task automatic check_model();
        for (int i = 0; i < 2; i++) begin
            int          rel;
            logic [31:0] exp_rn;
            rel    = rel_cnt(t_m[i], P_N[i], P_H[i], P_G[i]);
            exp_rn = (32'd1 << rel) - 32'd1;
            if (i == 0) begin
                chk("m0_resetN", {28'b0, rn0}, exp_rn);
                chk("m0_busy", {31'b0, busy0}, {31'b0, (rel < P_N[0])});
                chk("m0_done", {31'b0, done0}, {31'b0, done_m[0]});
                chk("m0_err", {31'b0, err0}, {31'b0, err_m[0]});
            end else begin
                chk("m1_resetN", {31'b0, rn1}, exp_rn);
                chk("m1_busy", {31'b0, busy1}, {31'b0, (rel < P_N[1])});
                chk("m1_done", {31'b0, done1}, {31'b0, done_m[1]});
                chk("m1_err", {31'b0, err1}, {31'b0, err_m[1]});
            end
        end
    endtask

    task automatic step(input logic r, input logic s, input logic [15:0] c);
        reset    = r;
        sw_req   = s;
        count_in = c;
        @(posedge clock);
        model_update(r, s, c);
        #1;
        check_model();
    endtask

    initial begin
        int pulses;
        reset    = 1'b1;
        sw_req   = 1'b0;
        count_in = 16'h0;
        for (int i = 0; i < 2; i++) begin
            t_m[i] = 0; err_m[i] = 1'b0; done_m[i] = 1'b0;
        end

        // Directed table: 3 reset cycles, then edges 1..21 with a clean counter.
        for (int i = 0; i < 24; i++) begin
            int e;
            e = i - 2;
            tbl[i].rst  = (i < 3);
            tbl[i].sw   = 1'b0;
            tbl[i].cnt  = 16'h0;
            tbl[i].err  = 1'b0;
            tbl[i].done = (e == 18);
            tbl[i].busy = (e < 18);
            if (e < 9)       tbl[i].rn = 4'b0000;
            else if (e < 12) tbl[i].rn = 4'b0001;
            else if (e < 15) tbl[i].rn = 4'b0011;
            else if (e < 18) tbl[i].rn = 4'b0111;
            else             tbl[i].rn = 4'b1111;
        end
        for (int i = 0; i < 24; i++) begin
            step(tbl[i].rst, tbl[i].sw, tbl[i].cnt);
            chk("tbl_resetN", {28'b0, rn0}, {28'b0, tbl[i].rn});
            chk("tbl_busy", {31'b0, busy0}, {31'b0, tbl[i].busy});
            chk("tbl_done", {31'b0, done0}, {31'b0, tbl[i].done});
            chk("tbl_err", {31'b0, err0}, {31'b0, tbl[i].err});
            if (i == 0) chk("rst_state", {29'b0, st0}, {29'b0, ASSERT});
        end

        // Nonzero counter at the check edge: sticky error, sequence completes.
        step(1'b1, 1'b0, 16'h0);
        for (int e = 1; e <= 20; e++) step(1'b0, 1'b0, (e == 9) ? 16'h0005 : 16'h0);
        chk("err_sticky", {31'b0, err0}, 32'd1);
        chk("err_seq_done", {28'b0, rn0}, 32'hF);

        // sw_req at edge 13 with two stages out: everything drops, restart.
        step(1'b1, 1'b0, 16'h0);
        for (int e = 1; e <= 12; e++) step(1'b0, 1'b0, (e == 9) ? 16'h0005 : 16'h0);
        chk("pre_sw_resetN", {28'b0, rn0}, 32'h3);
        step(1'b0, 1'b1, 16'h0);
        chk("sw13_resetN", {28'b0, rn0}, 32'h0);
        chk("sw13_err_clr", {31'b0, err0}, 32'd0);
        pulses = 0;
        for (int e = 14; e <= 21; e++) begin
            step(1'b0, 1'b0, 16'h0);
            if (done0) pulses++;
        end
        chk("sw13_no_done", pulses, 0);
        chk("sw13_edge21", {28'b0, rn0}, 32'h0);
        step(1'b0, 1'b0, 16'h0);
        chk("sw13_edge22", {28'b0, rn0}, 32'h1);

        // sw_req on the final release edge suppresses done.
        step(1'b1, 1'b0, 16'h0);
        for (int e = 1; e <= 17; e++) step(1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b1, 16'h0);
        chk("sw18_done", {31'b0, done0}, 32'd0);
        chk("sw18_resetN", {28'b0, rn0}, 32'h0);
        chk("sw18_busy", {31'b0, busy0}, 32'd1);
        for (int e = 19; e <= 26; e++) step(1'b0, 1'b0, 16'h0);
        chk("sw18_edge26", {28'b0, rn0}, 32'h0);
        step(1'b0, 1'b0, 16'h0);
        chk("sw18_edge27", {28'b0, rn0}, 32'h1);

        // reset mid-GAP at edge 10, then a full clean sequence.
        step(1'b1, 1'b0, 16'h0);
        for (int e = 1; e <= 9; e++) step(1'b0, 1'b0, 16'h0);
        step(1'b1, 1'b0, 16'h0);
        chk("rst10_resetN", {28'b0, rn0}, 32'h0);
        chk("rst10_busy", {31'b0, busy0}, 32'd1);
        for (int e = 1; e <= 17; e++) step(1'b0, 1'b0, 16'h0);
        chk("rst10_pre_done", {31'b0, done0}, 32'd0);
        step(1'b0, 1'b0, 16'h0);
        chk("rst10_done", {31'b0, done0}, 32'd1);
        chk("rst10_resetN_all", {28'b0, rn0}, 32'hF);

        // Single-stage instance: release and done at edge 2; held sw_req keeps it low.
        step(1'b1, 1'b0, 16'h0);
        step(1'b0, 1'b0, 16'h0);
        chk("s1_edge1", {31'b0, rn1}, 32'd0);
        step(1'b0, 1'b0, 16'h0);
        chk("s1_edge2_rn", {31'b0, rn1}, 32'd1);
        chk("s1_edge2_done", {31'b0, done1}, 32'd1);
        step(1'b0, 1'b0, 16'h0);
        chk("s1_edge3_done", {31'b0, done1}, 32'd0);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b1, 16'h0);
            chk("s1_held_rn", {31'b0, rn1}, 32'd0);
            chk("s1_held_busy", {31'b0, busy1}, 32'd1);
        end
        step(1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b0, 16'h0);
        chk("s1_after_hold", {31'b0, rn1}, 32'd1);

        // Random stimulus against the model.
        for (int k = 0; k < 600; k++) begin
            logic        r, s;
            logic [15:0] c;
            r = ($urandom_range(0, 63) == 0);
            s = ($urandom_range(0, 23) == 0);
            c = ($urandom_range(0, 1) == 0) ? 16'h0 : 16'($urandom);
            step(r, s, c);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
